vga_timing_640_480: RTL and testbench
=====================================

Name: vga_timing_640_480

Overview:
- Raster timing generator for 640x480 at 60 Hz. Sits directly upstream of the pattern/colour generator stage.
- Produces the pixel coordinates and visible-area enables that the colour stage consumes, plus the VGA sync outputs.
- Runs on the system clock and advances one pixel per i_px_clk enable pulse (25 MHz pixel rate).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (px)
H_SYNC, 96, hsync pulse width (px)
H_BACK, 48, horizontal back porch (px)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_sclr  in  1  synchronous clear, active high
i_px_clk  in  1  pixel-tick clock enable, one clk cycle wide
o_hidx  out  10  horizontal pixel index, valid while o_haddr_enb=1
o_vidx  out  9  vertical line index, valid while o_vaddr_enb=1
o_haddr_enb  out  1  high while hcnt < H_VISIBLE
o_vaddr_enb  out  1  high while vcnt < V_VISIBLE
o_vga_hsync  out  1  horizontal sync, active low
o_vga_vsync  out  1  vertical sync, active low
o_frame_start  out  1  one-clk pulse on entry to position (0,0)

Behaviour:
- Interface: single clock clk; reset i_rst_n is asynchronous and active-low.
- Derived totals: H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Internal counters: hcnt [9:0] runs 0..H_TOTAL-1; vcnt [9:0] runs 0..V_TOTAL-1.
- Counter advance, only on clk cycles with i_px_clk=1:
  - hcnt increments.
  - At hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
  - Cycles with i_px_clk=0: all state and outputs hold.
- Output registering: all outputs are registers decoded from the next counter value. They change on the same clk edge as the counters and always describe the current (hcnt, vcnt). No extra pipeline latency; all outputs stay mutually aligned.
- Decode:
  - o_haddr_enb = (hcnt < H_VISIBLE).
  - o_vaddr_enb = (vcnt < V_VISIBLE).
  - o_hidx = hcnt when o_haddr_enb, else 0.
  - o_vidx = vcnt[8:0] when o_vaddr_enb, else 0.
  - o_vga_hsync = 0 iff H_VISIBLE+H_FRONT <= hcnt < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - o_vga_vsync = 0 iff V_VISIBLE+V_FRONT <= vcnt < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the whole line including blanking.
- o_frame_start: 1 for exactly one clk cycle, on the px tick where the counters wrap from (799,524) to (0,0). 0 otherwise. Not asserted by reset or i_sclr.
- Reset (i_rst_n=0, asynchronous):
  - hcnt=0, vcnt=0.
  - o_hidx=0, o_vidx=0.
  - o_haddr_enb=1, o_vaddr_enb=1.
  - o_vga_hsync=1, o_vga_vsync=1.
  - o_frame_start=0.
  - Reset mid-frame aborts the frame; after release, counting restarts at (0,0) on the first i_px_clk.
- i_sclr=1: on the next clk edge, regardless of i_px_clk, forces the same values as reset. i_sclr has priority over counting.
- Simultaneous i_sclr and wrap: the clear wins and o_frame_start stays 0.
- i_px_clk held high continuously: the block advances once per clk (legal; used in simulation).
- Frame length: 800*525 = 420000 px ticks.

Test Plan:
- Reset release, i_px_clk every 4th clk: first 640 ticks -> o_hidx 0..639 and o_haddr_enb=1; tick 640 -> o_haddr_enb=0, o_hidx=0.
- Horizontal sync: hsync falls at hcnt=656, rises at hcnt=752, giving 96 ticks low. Line period 800 ticks; hcnt 799 -> 0 increments o_vidx.
- Vertical: o_vaddr_enb falls at vcnt=480; vsync low for vcnt 490..491 (1600 ticks); frame period 420000 ticks.
- Frame pulse: o_frame_start is high exactly one clk at each wrap to (0,0), 420000 ticks apart; never high after reset.
- i_px_clk=0 for 100 clk mid-line at hcnt=300: all outputs frozen; resumes at 301.
- Mid-frame disturbances:
  - i_rst_n asserted at (400,200) -> outputs immediately reset values, without waiting for clk.
  - i_sclr asserted at (799,524) together with i_px_clk -> (0,0) with o_frame_start=0.

Source files
------------

// File: rtl/vga_timing_640_480_if.sv
// Pixel-tick input and raster outputs of the 640x480 timing generator.
// The timing generator takes the master side; the colour stage takes the slave side.
interface vga_timing_640_480_if;
  logic       i_px_clk;
  logic [9:0] o_hidx;
  logic [8:0] o_vidx;
  logic       o_haddr_enb;
  logic       o_vaddr_enb;
  logic       o_vga_hsync;
  logic       o_vga_vsync;
  logic       o_frame_start;

  modport master (
    input  i_px_clk,
    output o_hidx,
    output o_vidx,
    output o_haddr_enb,
    output o_vaddr_enb,
    output o_vga_hsync,
    output o_vga_vsync,
    output o_frame_start
  );

  modport slave (
    output i_px_clk,
    input  o_hidx,
    input  o_vidx,
    input  o_haddr_enb,
    input  o_vaddr_enb,
    input  o_vga_hsync,
    input  o_vga_vsync,
    input  o_frame_start
  );
endinterface

// File: rtl/vga_timing_640_480.sv
// Raster timing generator: pixel/line counters advanced by a pixel-tick enable.
// Outputs are registered from the next counter value, so they always describe the current position.
module vga_timing_640_480 #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_sclr,
  vga_timing_640_480_if.master   vif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  function automatic logic in_span(input logic [9:0] cnt,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  function automatic logic [9:0] h_index(input logic [9:0] cnt);
    return (cnt < H_VIS) ? cnt : 10'd0;
  endfunction

  function automatic logic [8:0] v_index(input logic [9:0] cnt);
    return (cnt < V_VIS) ? cnt[8:0] : 9'd0;
  endfunction

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] hcnt_nxt;
  logic [9:0] vcnt_nxt;
  logic       wrap_nxt;

  logic [9:0] hidx_q;
  logic [8:0] vidx_q;
  logic       haddr_enb_q;
  logic       vaddr_enb_q;
  logic       hsync_q;
  logic       vsync_q;
  logic       frame_start_q;

  always_comb begin
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    wrap_nxt = 1'b0;
    if (vif.i_px_clk) begin
      if (hcnt == H_LAST) begin
        hcnt_nxt = 10'd0;
        if (vcnt == V_LAST) begin
          vcnt_nxt = 10'd0;
          wrap_nxt = 1'b1;
        end else begin
          vcnt_nxt = vcnt + 10'd1;
        end
      end else begin
        hcnt_nxt = hcnt + 10'd1;
      end
    end
  end

  // Counter and output register stage; a clear lands on the reset position and suppresses the frame pulse.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt          <= 10'd0;
      vcnt          <= 10'd0;
      hidx_q        <= 10'd0;
      vidx_q        <= 9'd0;
      haddr_enb_q   <= 1'b1;
      vaddr_enb_q   <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else if (i_sclr) begin
      hcnt          <= 10'd0;
      vcnt          <= 10'd0;
      hidx_q        <= 10'd0;
      vidx_q        <= 9'd0;
      haddr_enb_q   <= 1'b1;
      vaddr_enb_q   <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcnt          <= hcnt_nxt;
      vcnt          <= vcnt_nxt;
      hidx_q        <= h_index(hcnt_nxt);
      vidx_q        <= v_index(vcnt_nxt);
      haddr_enb_q   <= (hcnt_nxt < H_VIS);
      vaddr_enb_q   <= (vcnt_nxt < V_VIS);
      hsync_q       <= ~in_span(hcnt_nxt, H_SYNC_BEG, H_SYNC_END);
      vsync_q       <= ~in_span(vcnt_nxt, V_SYNC_BEG, V_SYNC_END);
      frame_start_q <= wrap_nxt;
    end
  end

  assign vif.o_hidx        = hidx_q;
  assign vif.o_vidx        = vidx_q;
  assign vif.o_haddr_enb   = haddr_enb_q;
  assign vif.o_vaddr_enb   = vaddr_enb_q;
  assign vif.o_vga_hsync   = hsync_q;
  assign vif.o_vga_vsync   = vsync_q;
  assign vif.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Bench for vga_timing_640_480: a full-size instance and a shrunken-raster instance share one stimulus,
// each checked every cycle against a tick-count position model.
module tb_vga_timing_640_480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sclr;
  logic px;

  int n_chk = 0;
  int n_err = 0;

  // Ticks since the last reset/clear; position follows from plain division.
  int   t;
  logic fs_f;
  logic fs_s;

  localparam int F_HT = 800, F_VT = 525;
  localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VV = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int F_FRAME = F_HT * F_VT;

  vga_timing_640_480_if bus_f ();
  vga_timing_640_480_if bus_s ();

  assign bus_f.i_px_clk = px;
  assign bus_s.i_px_clk = px;

  vga_timing_640_480 dut_f (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_sclr  (sclr),
    .vif     (bus_f)
  );

  vga_timing_640_480 #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) dut_s (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_sclr  (sclr),
    .vif     (bus_s)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic check_inst(input string who,
                            input int hv, input int hf, input int hs, input int ht,
                            input int vv, input int vf, input int vs, input int vt,
                            input logic fs_exp,
                            input logic [9:0] hidx, input logic [8:0] vidx,
                            input logic haddr, input logic vaddr,
                            input logic hsync, input logic vsync, input logic fstart);
    int   h;
    int   v;
    logic e_haddr;
    logic e_vaddr;
    h = t % ht;
    v = (t / ht) % vt;
    e_haddr = (h < hv);
    e_vaddr = (v < vv);
    chk({who, ".haddr_enb"},   {9'd0, haddr},  {9'd0, e_haddr});
    chk({who, ".vaddr_enb"},   {9'd0, vaddr},  {9'd0, e_vaddr});
    chk({who, ".hidx"},        hidx,           e_haddr ? 10'(h) : 10'd0);
    chk({who, ".vidx"},        {1'b0, vidx},   e_vaddr ? 10'(v) : 10'd0);
    chk({who, ".hsync"},       {9'd0, hsync},  {9'd0, !(h >= hv + hf && h < hv + hf + hs)});
    chk({who, ".vsync"},       {9'd0, vsync},  {9'd0, !(v >= vv + vf && v < vv + vf + vs)});
    chk({who, ".frame_start"}, {9'd0, fstart}, {9'd0, fs_exp});
  endtask

  task automatic check_both();
    check_inst("full", 640, 16, 96, F_HT, 480, 10, 2, F_VT, fs_f,
               bus_f.o_hidx, bus_f.o_vidx, bus_f.o_haddr_enb, bus_f.o_vaddr_enb,
               bus_f.o_vga_hsync, bus_f.o_vga_vsync, bus_f.o_frame_start);
    check_inst("small", S_HV, S_HF, S_HS, S_HT, S_VV, S_VF, S_VS, S_VT, fs_s,
               bus_s.o_hidx, bus_s.o_vidx, bus_s.o_haddr_enb, bus_s.o_vaddr_enb,
               bus_s.o_vga_hsync, bus_s.o_vga_vsync, bus_s.o_frame_start);
  endtask

  task automatic tick(input logic p, input logic c);
    px   = p;
    sclr = c;
    @(posedge clk);
    #1;
    if (!rst_n || c) begin
      t    = 0;
      fs_f = 1'b0;
      fs_s = 1'b0;
    end else if (p) begin
      t++;
      fs_f = (t % F_FRAME == 0);
      fs_s = (t % S_FRAME == 0);
    end else begin
      fs_f = 1'b0;
      fs_s = 1'b0;
    end
    check_both();
  endtask

  initial begin
    rst_n = 1'b0;
    sclr  = 1'b0;
    px    = 1'b0;
    t     = 0;
    fs_f  = 1'b0;
    fs_s  = 1'b0;

    #12;
    check_both();
    @(negedge clk);
    rst_n = 1'b1;

    // One full line at one tick per four clocks: visible run, blanking, hsync, line wrap.
    repeat (F_HT) begin
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end

    // Park the full raster at hcnt=300, freeze for 100 clocks, then resume.
    repeat (300) tick(1'b1, 1'b0);
    repeat (100) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    repeat (3000) tick(1'($urandom_range(0, 1)), 1'b0);

    // Clear together with the tick that would wrap the small raster to (0,0).
    while (t % S_FRAME != S_FRAME - 1) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);

    repeat (37) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);

    // Asynchronous reset mid-frame, observed before any clock edge.
    repeat (150) tick(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    t    = 0;
    fs_f = 1'b0;
    fs_s = 1'b0;
    check_both();
    repeat (3) tick(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    repeat (2000) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    repeat (2 * S_FRAME + 50) tick(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
